// File: rtl/uart_tx_scheduler.sv
// Four-way round-robin arbiter feeding an 8N1/8N2 UART transmitter.
// Bit timing comes from a clock-enable counter on clk; one requester is granted per frame.
module uart_tx_scheduler #(
   parameter int BAUD_DIV  = 10416,
   parameter int STOP_BITS = 1
) (
   input  logic        clk,
   input  logic        reset,
   input  logic [3:0]  req,
   input  logic [31:0] req_data,
   output logic [3:0]  gnt,
   output logic        busy,
   output logic        done,
   output logic        tx
);

   localparam int unsigned CW = (BAUD_DIV > 2) ? $clog2(BAUD_DIV) : 1;
   localparam logic [CW-1:0] BAUD_LAST = CW'(BAUD_DIV - 1);
   localparam logic [2:0]    STOP_LAST = 3'(STOP_BITS - 1);

   typedef enum logic [1:0] {
      IDLE,
      START,
      DATA,
      STOP
   } state_t;

   state_t        state;
   logic [CW-1:0] baud_cnt;
   logic [2:0]    bit_idx;
   logic [7:0]    shreg;
   logic [1:0]    last_grant;

   logic [1:0]    pick;
   logic          pick_valid;
   logic [1:0]    cand;
   logic          bit_end;

   // Search starts one past the last winner; offset 4 wraps back to last_grant itself.
   always_comb begin
      pick       = last_grant;
      pick_valid = 1'b0;
      cand       = last_grant;
      for (int unsigned i = 1; i <= 4; i++) begin
         cand = last_grant + 2'(i);
         if (!pick_valid && req[cand]) begin
            pick       = cand;
            pick_valid = 1'b1;
         end
      end
   end

   assign bit_end = (baud_cnt == BAUD_LAST);

   always_ff @(posedge clk) begin
      if (reset) begin
         state      <= IDLE;
         tx         <= 1'b1;
         gnt        <= '0;
         busy       <= 1'b0;
         done       <= 1'b0;
         baud_cnt   <= '0;
         bit_idx    <= '0;
         shreg      <= '0;
         last_grant <= 2'd3;
      end else begin
         gnt  <= '0;
         done <= 1'b0;
         case (state)
            IDLE: begin
               tx <= 1'b1;
               if (pick_valid) begin
                  shreg      <= req_data[{pick, 3'b000} +: 8];
                  gnt        <= 4'b0001 << pick;
                  last_grant <= pick;
                  baud_cnt   <= '0;
                  bit_idx    <= '0;
                  tx         <= 1'b0;
                  busy       <= 1'b1;
                  state      <= START;
               end
            end

            START: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  bit_idx  <= '0;
                  tx       <= shreg[0];
                  state    <= DATA;
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            // tx is registered, so the bit after the shift (shreg[1]) is loaded at the boundary.
            DATA: begin
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == 3'd7) begin
                     bit_idx <= '0;
                     tx      <= 1'b1;
                     state   <= STOP;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                     shreg   <= {1'b0, shreg[7:1]};
                     tx      <= shreg[1];
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            STOP: begin
               tx <= 1'b1;
               if (bit_end) begin
                  baud_cnt <= '0;
                  if (bit_idx == STOP_LAST) begin
                     bit_idx <= '0;
                     busy    <= 1'b0;
                     done    <= 1'b1;
                     state   <= IDLE;
                  end else begin
                     bit_idx <= bit_idx + 1'b1;
                  end
               end else begin
                  baud_cnt <= baud_cnt + 1'b1;
               end
            end

            default: begin
               tx    <= 1'b1;
               busy  <= 1'b0;
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_uart_tx_scheduler.sv
// Scoreboard bench for uart_tx_scheduler with BAUD_DIV=4, STOP_BITS=1 (40-clock frames).
module tb_uart_tx_scheduler;

   localparam int BD    = 4;
   localparam int FRAME = 10 * BD;

   logic        clk = 1'b0;
   logic        reset = 1'b1;
   logic [3:0]  req = '0;
   logic [31:0] req_data = '0;
   logic [3:0]  gnt;
   logic        busy;
   logic        done;
   logic        tx;

   uart_tx_scheduler #(
      .BAUD_DIV (BD),
      .STOP_BITS(1)
   ) dut (
      .clk     (clk),
      .reset   (reset),
      .req     (req),
      .req_data(req_data),
      .gnt     (gnt),
      .busy    (busy),
      .done    (done),
      .tx      (tx)
   );

   always #5 clk = ~clk;

   typedef struct {
      int         id;
      logic [7:0] data;
   } exp_t;

   exp_t exp_q[$];

   int checks = 0;
   int failures = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      checks++;
      if (got !== exp) begin
         failures++;
         $display("FAIL %s got=0x%0h exp=0x%0h", tag, got, exp);
      end
   endtask

   task automatic expect_frame(input int id, input logic [7:0] data);
      exp_t e;
      e.id   = id;
      e.data = data;
      exp_q.push_back(e);
   endtask

   // Frame monitor: offset 0 is the gnt cycle, which is also the first start-bit cycle.
   int         cyc = 0;
   int         off = 0;
   int         last_done_cyc = -10;
   int         gnt_seen = 0;
   int         b2b = 0;
   logic       active = 1'b0;
   logic [9:0] bits = '0;
   logic [7:0] cur_byte = '0;

   always @(negedge clk) begin
      exp_t e;
      cyc++;
      if (reset) begin
         active = 1'b0;
      end else begin
         if (gnt != 4'b0000) begin
            gnt_seen++;
            if (exp_q.size() == 0) begin
               check("unexpected_gnt", 32'(gnt), 32'h0);
               cur_byte = 8'hxx;
            end else begin
               e = exp_q.pop_front();
               check("gnt_id", 32'(gnt), 32'(4'b0001 << e.id));
               cur_byte = e.data;
            end
            if (last_done_cyc == cyc - 1) b2b++;
            active = 1'b1;
            off    = 0;
            bits   = '0;
            check("start_tx_at_gnt", 32'(tx), 32'h0);
         end
         if (active) begin
            if (off < FRAME) begin
               check("busy_in_frame", 32'(busy), 32'h1);
               check("no_early_done", 32'(done), 32'h0);
               if (off % BD == BD / 2) bits[off / BD] = tx;
            end else begin
               check("done_pulse", 32'(done), 32'h1);
               check("busy_after", 32'(busy), 32'h0);
               check("tx_idle_at_done", 32'(tx), 32'h1);
               check("frame_bits", 32'(bits), 32'({1'b1, cur_byte, 1'b0}));
               active = 1'b0;
            end
            off++;
         end else if (done) begin
            check("stray_done", 32'(done), 32'h0);
         end
         if (done) last_done_cyc = cyc;
      end
   end

   task automatic tick(input int n);
      repeat (n) @(posedge clk);
      #1;
   endtask

   task automatic wait_gnt(input int budget);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (gnt == 4'b0000 && n < budget);
      check("gnt_arrived", 32'(gnt != 4'b0000), 32'h1);
   endtask

   task automatic wait_done(input int budget);
      int n = 0;
      do begin
         tick(1);
         n++;
      end while (!done && n < budget);
      check("done_arrived", 32'(done), 32'h1);
   endtask

   task automatic do_reset();
      reset = 1'b1;
      tick(2);
      reset = 1'b0;
   endtask

   initial begin
      #1000000;
      $display("FAIL watchdog got=timeout exp=finish");
      $fatal(1, "watchdog expired");
   end

   initial begin
      int g0;
      int b0;
      int lows;

      tick(3);
      check("reset_tx", 32'(tx), 32'h1);
      check("reset_gnt", 32'(gnt), 32'h0);
      check("reset_busy", 32'(busy), 32'h0);
      check("reset_done", 32'(done), 32'h0);
      reset = 1'b0;
      tick(2);

      // Single request, byte 0xA5
      req_data = 32'h0000_00A5;
      expect_frame(0, 8'hA5);
      req = 4'b0001;
      wait_gnt(20);
      req = '0;
      wait_done(60);
      tick(3);

      // All four requesting from reset: 0,1,2,3,0 back to back
      do_reset();
      req_data = 32'h4433_2211;
      expect_frame(0, 8'h11);
      expect_frame(1, 8'h22);
      expect_frame(2, 8'h33);
      expect_frame(3, 8'h44);
      expect_frame(0, 8'h11);
      b0 = b2b;
      req = 4'b1111;
      for (int i = 0; i < 5; i++) wait_gnt(60);
      req = '0;
      wait_done(60);
      check("b2b_one_clock_gaps", 32'(b2b - b0), 32'd4);
      tick(3);

      // Rotation skip: last grant 1, then 1001 -> 3 then 0
      req_data = 32'hD400_6BE7;
      expect_frame(1, 8'h6B);
      req = 4'b0010;
      wait_gnt(20);
      req = '0;
      wait_done(60);
      expect_frame(3, 8'hD4);
      expect_frame(0, 8'hE7);
      req = 4'b1001;
      wait_gnt(20);
      wait_gnt(60);
      req = '0;
      wait_done(60);
      tick(3);

      // Withdrawal: requester 2 raised and dropped inside a frame
      req_data = 32'h0077_005A;
      expect_frame(0, 8'h5A);
      req = 4'b0001;
      wait_gnt(20);
      req = '0;
      tick(8);
      req = 4'b0100;
      tick(10);
      req = '0;
      wait_done(60);
      g0 = gnt_seen;
      lows = 0;
      for (int i = 0; i < 20; i++) begin
         tick(1);
         if (tx !== 1'b1) lows++;
      end
      check("withdraw_tx_idle", 32'(lows), 32'h0);
      check("withdraw_no_gnt", 32'(gnt_seen - g0), 32'h0);
      check("withdraw_not_busy", 32'(busy), 32'h0);

      // Reset during DATA bit 3 of 0x00
      req_data = 32'h0000_9600;
      expect_frame(0, 8'h00);
      req = 4'b0001;
      wait_gnt(20);
      req = '0;
      tick(16);
      reset = 1'b1;
      tick(1);
      check("midreset_tx", 32'(tx), 32'h1);
      check("midreset_busy", 32'(busy), 32'h0);
      check("midreset_done", 32'(done), 32'h0);
      check("midreset_gnt", 32'(gnt), 32'h0);
      reset = 1'b0;
      tick(3);
      expect_frame(1, 8'h96);
      req = 4'b0010;
      wait_gnt(20);
      req = '0;
      wait_done(60);
      tick(3);

      // req_data changed the cycle after grant must not leak into the frame
      req_data = 32'h003C_0000;
      expect_frame(2, 8'h3C);
      req = 4'b0100;
      wait_gnt(20);
      req = '0;
      tick(1);
      req_data = 32'h00C3_0000;
      wait_done(60);
      tick(5);

      check("scoreboard_drained", 32'(exp_q.size()), 32'h0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
